// File: rtl/injector_pkg.sv
// Shared definitions for the injector peak-and-hold controller.
//
// Contents:
//   inj_state_t    - per-channel FSM state encoding (IDLE=0, PEAK=1, HOLD_ON=2,
//                    HOLD_OFF=3, FAULT=4)
//   PHASE_*        - two-bit phase codes reported on o_phase
//   DEFAULT_*      - default channel count and timing constants
//   phase_of()     - state -> phase code decode
//   drive_of()     - state -> gate drive decode (on only in PEAK and HOLD_ON)
package injector_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PEAK     = 3'd1,
        HOLD_ON  = 3'd2,
        HOLD_OFF = 3'd3,
        FAULT    = 3'd4
    } inj_state_t;

    localparam logic [1:0] PHASE_IDLE     = 2'd0;  // also reported for FAULT
    localparam logic [1:0] PHASE_PEAK     = 2'd1;
    localparam logic [1:0] PHASE_HOLD_ON  = 2'd2;
    localparam logic [1:0] PHASE_HOLD_OFF = 2'd3;

    localparam int DEFAULT_CHANNELS     = 4;
    localparam int DEFAULT_PEAK_TIMEOUT = 4000;
    localparam int DEFAULT_MIN_OFF      = 8;

    function automatic logic [1:0] phase_of(inj_state_t s);
        logic [1:0] p;
        case (s)
            PEAK:     p = PHASE_PEAK;
            HOLD_ON:  p = PHASE_HOLD_ON;
            HOLD_OFF: p = PHASE_HOLD_OFF;
            default:  p = PHASE_IDLE;
        endcase
        return p;
    endfunction

    function automatic logic drive_of(inj_state_t s);
        return (s == PEAK) || (s == HOLD_ON);
    endfunction

endpackage

// File: rtl/injector_channel.sv
// Single injector channel: sense synchronizers, peak/hold FSM, cycle counter
// and sticky peak-timeout fault bit.
//
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   enable       - injection window (synchronous, level)
//   peak_sense   - peak-current comparator (asynchronous)
//   hold_sense   - hold-current comparator (asynchronous)
//   tick         - one-cycle chop re-arm tick (synchronous)
//   fault_clear  - one-cycle pulse clearing the sticky fault
//   drive        - registered gate drive, high = on
//   fault        - sticky peak-timeout fault
//   state        - current FSM state (debug / phase decode)
module injector_channel
    import injector_pkg::*;
#(
    parameter int PEAK_TIMEOUT = DEFAULT_PEAK_TIMEOUT,
    parameter int MIN_OFF      = DEFAULT_MIN_OFF,
    parameter int CNT_W        = $clog2(PEAK_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       peak_sense,
    input  logic       hold_sense,
    input  logic       tick,
    input  logic       fault_clear,
    output logic       drive,
    output logic       fault,
    output inj_state_t state
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PEAK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_CNT  = CNT_W'(MIN_OFF);

    logic [1:0]       peak_sync;
    logic [1:0]       hold_sync;
    logic             peak_s;
    logic             hold_s;
    inj_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Two-flop synchronizers; bit 1 is the only copy the FSM looks at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_sync <= 2'b00;
            hold_sync <= 2'b00;
        end else begin
            peak_sync <= {peak_sync[0], peak_sense};
            hold_sync <= {hold_sync[0], hold_sense};
        end
    end

    assign peak_s = peak_sync[1];
    assign hold_s = hold_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            drive <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            // Drive is decoded from the next state so it changes together
            // with the state register and cannot glitch.
            drive <= drive_of(state_next);
            // Entry into FAULT outranks a simultaneous clear.
            if ((state_next == FAULT) && (state != FAULT)) begin
                fault <= 1'b1;
            end else if (fault_clear) begin
                fault <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = PEAK;
                end
            end

            PEAK: begin
                // Leaves at TIMEOUT_LAST at the latest, so this never wraps.
                cnt_next = cnt + CNT_W'(1);
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (peak_s) begin
                    // Sense beats a timeout landing on the same cycle.
                    state_next = HOLD_OFF;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = FAULT;
                    cnt_next   = '0;
                end
            end

            HOLD_OFF: begin
                if (cnt < MIN_OFF_CNT) begin
                    cnt_next = cnt + CNT_W'(1);
                end
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if ((cnt >= MIN_OFF_CNT) && tick) begin
                    // Ticks before the minimum off time are simply dropped.
                    state_next = HOLD_ON;
                    cnt_next   = '0;
                end
            end

            HOLD_ON: begin
                cnt_next = '0;
                if (!enable) begin
                    state_next = IDLE;
                end else if (hold_s) begin
                    state_next = HOLD_OFF;
                end
            end

            FAULT: begin
                cnt_next = '0;
                if (!enable) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/injector_peak_hold_ctrl.sv
// Peak-and-hold current controller for CHANNELS fuel injectors. Each channel
// runs its own injector_channel instance; this level only fans the buses out
// and packs the per-channel outputs back together.
//
// Ports:
//   i_clock          - system clock
//   i_reset          - asynchronous active-low reset
//   i_enable         - per-channel injection window
//   i_peakSense      - per-channel peak comparator (asynchronous)
//   i_holdSense      - per-channel hold comparator (asynchronous)
//   i_periodPhased   - per-channel chop tick
//   i_faultClear     - per-channel sticky fault clear pulse
//   o_injectorDrive  - per-channel gate drive, high = on
//   o_fault          - per-channel sticky peak-timeout fault
//   o_phase          - 2 bits per channel: 0 idle/fault, 1 peak, 2 hold-on,
//                      3 hold-off; channel n at [2n+1:2n]
module injector_peak_hold_ctrl
    import injector_pkg::*;
#(
    parameter int CHANNELS     = DEFAULT_CHANNELS,
    parameter int PEAK_TIMEOUT = DEFAULT_PEAK_TIMEOUT,
    parameter int MIN_OFF      = DEFAULT_MIN_OFF,
    parameter int CNT_W        = $clog2(PEAK_TIMEOUT + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [CHANNELS-1:0]   i_enable,
    input  logic [CHANNELS-1:0]   i_peakSense,
    input  logic [CHANNELS-1:0]   i_holdSense,
    input  logic [CHANNELS-1:0]   i_periodPhased,
    input  logic [CHANNELS-1:0]   i_faultClear,
    output logic [CHANNELS-1:0]   o_injectorDrive,
    output logic [CHANNELS-1:0]   o_fault,
    output logic [2*CHANNELS-1:0] o_phase
);

    inj_state_t ch_state [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        injector_channel #(
            .PEAK_TIMEOUT (PEAK_TIMEOUT),
            .MIN_OFF      (MIN_OFF),
            .CNT_W        (CNT_W)
        ) u_channel (
            .clk         (i_clock),
            .rst_n       (i_reset),
            .enable      (i_enable[g]),
            .peak_sense  (i_peakSense[g]),
            .hold_sense  (i_holdSense[g]),
            .tick        (i_periodPhased[g]),
            .fault_clear (i_faultClear[g]),
            .drive       (o_injectorDrive[g]),
            .fault       (o_fault[g]),
            .state       (ch_state[g])
        );

        // Decoded straight from the state register, so reset forces 0 at once.
        assign o_phase[2*g +: 2] = phase_of(ch_state[g]);
    end

endmodule

// File: tb/tb_injector_peak_hold_ctrl.sv
// Self-checking bench for injector_peak_hold_ctrl (4 channels, timeout 4000,
// minimum off time 8). Inputs change and outputs are sampled on the falling
// clock edge; the DUT acts on the rising edge.
module tb_injector_peak_hold_ctrl;

    localparam int CH      = 4;
    localparam int PEAK_TO = 4000;
    localparam int MIN_OFF = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   enable;
    logic [CH-1:0]   peak_sense;
    logic [CH-1:0]   hold_sense;
    logic [CH-1:0]   period_phased;
    logic [CH-1:0]   fault_clear;
    logic [CH-1:0]   drive;
    logic [CH-1:0]   fault;
    logic [2*CH-1:0] phase;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    injector_peak_hold_ctrl #(
        .CHANNELS     (CH),
        .PEAK_TIMEOUT (PEAK_TO),
        .MIN_OFF      (MIN_OFF)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_enable        (enable),
        .i_peakSense     (peak_sense),
        .i_holdSense     (hold_sense),
        .i_periodPhased  (period_phased),
        .i_faultClear    (fault_clear),
        .o_injectorDrive (drive),
        .o_fault         (fault),
        .o_phase         (phase)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic compare_next(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sense pulse then wait until the channel has just entered HOLD_OFF.
    task automatic peak_to_hold_off(input int ch);
        peak_sense[ch] = 1'b1;
        step(1);
        peak_sense[ch] = 1'b0;
        step(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hi;
        logic        fault_early;
        logic        prev_drive;
        int          off_len;
        int          min_off_seen;
        int          rises;
        logic        exp_on;

        rst_n         = 1'b0;
        enable        = '0;
        peak_sense    = '0;
        hold_sense    = '0;
        period_phased = '0;
        fault_clear   = '0;

        // ---------------- reset ----------------
        expect_val("rst_drive", 32'h0);
        expect_val("rst_fault", 32'h0);
        expect_val("rst_phase", 32'h0);
        step(3);
        compare_next(32'(drive));
        compare_next(32'(fault));
        compare_next(32'(phase));
        rst_n = 1'b1;
        expect_val("idle_drive", 32'h0);
        step(2);
        compare_next(32'(drive));

        // ---------------- ch0: peak then sense ----------------
        enable[0] = 1'b1;
        expect_val("ch0_drive_on_next", 32'h1);
        expect_val("ch0_phase_peak", 32'h1);
        step(1);
        compare_next(32'(drive[0]));
        compare_next(32'(phase[1:0]));
        step(49);
        peak_sense[0] = 1'b1;
        expect_val("ch0_sense_edge1", 32'h1);
        step(1);
        compare_next(32'(drive[0]));
        expect_val("ch0_sense_edge2", 32'h1);
        step(1);
        compare_next(32'(drive[0]));
        expect_val("ch0_sense_edge3_off", 32'h0);
        expect_val("ch0_phase_hold_off", 32'h3);
        step(1);
        compare_next(32'(drive[0]));
        compare_next(32'(phase[1:0]));
        peak_sense[0] = 1'b0;

        // ---------------- ch1: hold chopping ----------------
        enable[1] = 1'b1;
        expect_val("ch1_drive_on", 32'h1);
        step(1);
        compare_next(32'(drive[1]));
        step(5);
        expect_val("ch1_enter_hold_off", 32'h3);
        peak_to_hold_off(1);
        compare_next(32'(phase[3:2]));

        // Ticks at t%20==5 (too soon after a chop) and t%20==15 (valid);
        // hold sense pulses 5 cycles after each re-on.
        prev_drive   = 1'b0;
        off_len      = 1;
        min_off_seen = 1000;
        rises        = 0;
        for (int t = 0; t < 100; t++) begin
            period_phased[1] = ((t % 20) == 5) || ((t % 20) == 15);
            hold_sense[1]    = (t >= 20) && ((t % 20) == 0);
            exp_on = (t >= 15) && (((t % 20) >= 15) || ((t % 20) <= 1));
            expect_val("ch1_chop_drive", 32'(exp_on));
            expect_val("ch1_chop_phase", exp_on ? 32'h2 : 32'h3);
            step(1);
            compare_next(32'(drive[1]));
            compare_next(32'(phase[3:2]));
            if (drive[1] && !prev_drive) begin
                rises++;
                if (off_len < min_off_seen) min_off_seen = off_len;
            end
            off_len    = drive[1] ? 0 : off_len + 1;
            prev_drive = drive[1];
        end
        period_phased[1] = 1'b0;
        hold_sense[1]    = 1'b0;
        check("ch1_rise_count", 32'(rises), 32'd5);
        check("ch1_min_off_ok", 32'(min_off_seen >= MIN_OFF), 32'h1);
        check("ch0_still_hold_off", 32'(phase[1:0]), 32'h3);

        // ---------------- ch2: peak timeout ----------------
        enable[2] = 1'b1;
        step(1);
        hi          = 0;
        fault_early = 1'b0;
        expect_val("ch2_peak_len", 32'(PEAK_TO));
        for (int i = 0; i < PEAK_TO + 50 && drive[2] === 1'b1; i++) begin
            hi++;
            fault_early = fault_early | fault[2];
            step(1);
        end
        compare_next(32'(hi));
        check("ch2_no_early_fault", 32'(fault_early), 32'h0);
        check("ch2_fault_set", 32'(fault[2]), 32'h1);
        check("ch2_fault_phase", 32'(phase[5:4]), 32'h0);
        expect_val("ch2_fault_held", 32'h1);
        expect_val("ch2_fault_drive_off", 32'h0);
        step(5);
        compare_next(32'(fault[2]));
        compare_next(32'(drive[2]));
        enable[2] = 1'b0;
        expect_val("ch2_sticky_after_idle", 32'h1);
        step(1);
        compare_next(32'(fault[2]));
        fault_clear[2] = 1'b1;
        expect_val("ch2_fault_cleared", 32'h0);
        step(1);
        fault_clear[2] = 1'b0;
        compare_next(32'(fault[2]));

        enable[2] = 1'b1;
        expect_val("ch2_rerun_on", 32'h1);
        step(1);
        compare_next(32'(drive[2]));
        expect_val("ch2_last_peak_cycle", 32'h1);
        step(PEAK_TO - 1);
        compare_next(32'(drive[2]));
        fault_clear[2] = 1'b1;
        expect_val("ch2_set_beats_clear", 32'h1);
        expect_val("ch2_timeout_off", 32'h0);
        step(1);
        fault_clear[2] = 1'b0;
        compare_next(32'(fault[2]));
        compare_next(32'(drive[2]));

        // ---------------- ch3: enable drops ----------------
        enable[3] = 1'b1;
        expect_val("ch3_peak_on", 32'h1);
        step(1);
        compare_next(32'(drive[3]));
        step(3);
        enable[3] = 1'b0;
        expect_val("ch3_drop_in_peak", 32'h0);
        step(1);
        compare_next(32'(drive[3]));

        enable[3] = 1'b1;
        step(1);
        peak_to_hold_off(3);
        step(10);
        period_phased[3] = 1'b1;
        expect_val("ch3_hold_on_phase", 32'h2);
        expect_val("ch3_hold_on_drive", 32'h1);
        step(1);
        period_phased[3] = 1'b0;
        compare_next(32'(phase[7:6]));
        compare_next(32'(drive[3]));
        enable[3] = 1'b0;
        expect_val("ch3_drop_in_hold_on", 32'h0);
        step(1);
        compare_next(32'(drive[3]));

        enable[3] = 1'b1;
        step(1);
        expect_val("ch3_in_hold_off", 32'h3);
        peak_to_hold_off(3);
        compare_next(32'(phase[7:6]));
        step(2);
        enable[3] = 1'b0;
        expect_val("ch3_drop_in_hold_off", 32'h0);
        step(1);
        compare_next(32'(phase[7:6]));
        check("ch0_undisturbed", 32'(phase[1:0]), 32'h3);
        check("ch1_undisturbed", 32'(phase[3:2]), 32'h2);

        // ---------------- async reset during HOLD_ON ----------------
        check("ch1_on_before_reset", 32'(drive[1]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_drive", 32'(drive), 32'h0);
        check("async_rst_fault", 32'(fault), 32'h0);
        check("async_rst_phase", 32'(phase), 32'h0);
        step(1);
        rst_n = 1'b1;
        expect_val("restart_drive", 32'h7);
        expect_val("restart_phase", 32'h15);
        step(1);
        compare_next(32'(drive));
        compare_next(32'(phase));

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
